lsu_mem_ctrl: RTL and testbench

//   Load/store unit sitting directly upstream of the word-aligned dual-port data memory.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_align.sv | 47 ++++
 rtl/lsu_mem_ctrl.sv | 122 ++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states, alignment check.
package lsu_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_RESP = 3'd3,
    S_ERR  = 3'd4
  } lsu_state_e;

  // Size 2'b11 is illegal and is reported through the same error path as misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      MEM_B:   is_misaligned = 1'b0;
      MEM_H:   is_misaligned = lane[0];
      MEM_W:   is_misaligned = (lane != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extraction with sign/zero extension and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      lane,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] wdata_rep;
  logic [3:0]      lane_mask;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves a latch.
    shifted   = rdata >> {lane, 3'b000};
    load_data = rdata;
    wdata_rep = wdata;
    lane_mask = 4'b1111;

    case (size)
      MEM_B: begin
        load_data = {{(XLEN-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
        wdata_rep = {4{wdata[7:0]}};
        lane_mask = 4'b0001 << lane;
      end
      MEM_H: begin
        load_data = {{(XLEN-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
        wdata_rep = {2{wdata[15:0]}};
        lane_mask = 4'b0011 << lane;
      end
      default: ;
    endcase

    // Replicated store data lets each byte lane pick either the old or the new byte directly.
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = lane_mask[i] ? wdata_rep[8*i +: 8] : rdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of a word-wide synchronous memory; sub-word stores use read-modify-write.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MEM_AW = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [MEM_AW-1:0] mem_raddr_o,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_waddr_o,
  output logic [XLEN-1:0]   mem_wdata_o
);

  lsu_state_e      state_q, state_d;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] wbuf_q;
  logic [XLEN-1:0] rdata_q;
  logic            accept;
  logic            req_bad;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged;

  assign req_bad = is_misaligned(req_size_i, req_addr_i[1:0]);
  assign accept  = req_valid_i & req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (req_bad)                               state_d = S_ERR;
          else if (req_we_i && req_size_i == MEM_W)  state_d = S_WR;
          else                                       state_d = S_RD;
        end
      end
      S_RD:   state_d = we_q ? S_WR : S_RESP;
      S_WR:   state_d = S_RESP;
      S_RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = S_IDLE;
      end
      S_ERR: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        wbuf_q  <= req_wdata_i;
        // Stores and errors respond with zero data; loads overwrite this in RD.
        if (req_we_i || req_bad) rdata_q <= '0;
      end
      if (state_q == S_RD) begin
        if (we_q) wbuf_q  <= merged;
        else      rdata_q <= load_data;
      end
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .rdata       (mem_rdata_i),
    .lane        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  // In IDLE the request address goes straight out so the memory samples it on the accept edge.
  assign mem_raddr_o = (state_q == S_IDLE) ? req_addr_i[MEM_AW+1:2] : addr_q[MEM_AW+1:2];
  assign mem_we_o    = (state_q == S_WR);
  assign mem_waddr_o = addr_q[MEM_AW+1:2];
  assign mem_wdata_o = wbuf_q;
  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_lsu_mem_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [9:0]  mem_raddr_o, mem_waddr_o;
  logic [31:0] mem_rdata_i, mem_wdata_o;
  logic        mem_we_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_we_o) mem[mem_waddr_o] <= mem_wdata_o;
    mem_rdata_i <= mem[mem_raddr_o];
  end

  lsu_mem_ctrl #(.XLEN(32), .MEM_AW(10)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_raddr_o    (mem_raddr_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_we_o       (mem_we_o),
    .mem_waddr_o    (mem_waddr_o),
    .mem_wdata_o    (mem_wdata_o)
  );

  // Reference model: plain byte arithmetic on whole words.
  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic ref_bad(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b1;
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input int lane,
                                           input logic [1:0] size, input logic uns);
    int n = nbytes(size);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
    logic [31:0] v = (word >> (8 * lane)) & mask;
    if (!uns && n < 4 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input int lane,
                                            input logic [1:0] size, input logic [31:0] wdata);
    int n = nbytes(size);
    logic [31:0] mask = ((n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1)) << (8 * lane);
    return (word & ~mask) | ((wdata << (8 * lane)) & mask);
  endfunction

  // Issues one request and records what the DUT did until its response (bounded).
  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output int n_we, output logic [9:0] waddr_seen, output logic timed_out);
    int wait_cnt = 0;
    rdata = '0; err = 1'b0; lat = 0; n_we = 0; waddr_seen = '0; timed_out = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata;
    while (!req_ready_o && wait_cnt < 20) begin
      @(negedge clk_i);
      wait_cnt++;
    end
    if (!req_ready_o) begin
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      if (mem_we_o) begin
        n_we++;
        waddr_seen = mem_waddr_o;
      end
      if (rsp_valid_o) begin
        lat = c; rdata = rsp_rdata_o; err = rsp_err_o; timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    repeat (3) @(negedge clk_i);
    tests_run++;
    if ({req_ready_o, rsp_valid_o, rsp_err_o, mem_we_o, rsp_rdata_o} !== {4'b1000, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_hold: ready/valid/err/we=%b%b%b%b rdata=%h, expected 1000 rdata=0",
               req_ready_o, rsp_valid_o, rsp_err_o, mem_we_o, rsp_rdata_o);
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    tests_run++;
    if ({req_ready_o, rsp_valid_o, mem_we_o} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_release: ready/valid/we=%b%b%b, expected 100",
               req_ready_o, rsp_valid_o, mem_we_o);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic err, to; int lat, nwe; logic [9:0] wa;
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, err, lat, nwe, wa, to);
    tests_run++;
    if (to || nwe != 1 || wa !== 10'd4 || lat != 2 || err !== 1'b0 || rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL sw_word: to=%0d we_cycles=%0d waddr=%0d lat=%0d err=%b rdata=%h, expected we_cycles=1 waddr=4 lat=2 err=0 rdata=0",
               to, nwe, wa, lat, err, rd);
    end
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, lat, nwe, wa, to);
    tests_run++;
    if (to || rd !== 32'hDEAD_BEEF || lat != 2 || err !== 1'b0 || nwe != 0) begin
      tests_failed++;
      $display("FAIL lw_word: to=%0d rdata=%h lat=%0d err=%b we_cycles=%0d, expected DEADBEEF lat=2 err=0 we_cycles=0",
               to, rd, lat, err, nwe);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic err, to; int lat, nwe; logic [9:0] wa;
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, rd, err, lat, nwe, wa, to);
    do_op(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00AA, rd, err, lat, nwe, wa, to);
    tests_run++;
    if (to || lat != 3 || nwe != 1 || wa !== 10'd4 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_latency: to=%0d lat=%0d we_cycles=%0d waddr=%0d err=%b, expected lat=3 we_cycles=1 waddr=4 err=0",
               to, lat, nwe, wa, err);
    end
    tests_run++;
    if (mem[4] !== 32'hAA22_3344) begin
      tests_failed++;
      $display("FAIL sb_merge: mem[4]=%h, expected AA223344", mem[4]);
    end
    do_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, err, lat, nwe, wa, to);
    tests_run++;
    if (to || rd !== 32'hFFFF_FFAA || lat != 2) begin
      tests_failed++;
      $display("FAIL lb_signed: rdata=%h lat=%0d to=%0d, expected FFFFFFAA lat=2", rd, lat, to);
    end
    do_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, err, lat, nwe, wa, to);
    tests_run++;
    if (to || rd !== 32'h0000_00AA) begin
      tests_failed++;
      $display("FAIL lbu: rdata=%h to=%0d, expected 000000AA", rd, to);
    end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic err, to; int lat, nwe; logic [9:0] wa;
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_0000, rd, err, lat, nwe, wa, to);
    do_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, err, lat, nwe, wa, to);
    tests_run++;
    if (to || rd !== 32'hFFFF_8001) begin
      tests_failed++;
      $display("FAIL lh_signed: rdata=%h to=%0d, expected FFFF8001", rd, to);
    end
    do_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, err, lat, nwe, wa, to);
    tests_run++;
    if (to || rd !== 32'h0000_8001) begin
      tests_failed++;
      $display("FAIL lhu: rdata=%h to=%0d, expected 00008001", rd, to);
    end
    do_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, err, lat, nwe, wa, to);
    tests_run++;
    if (to || rd !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL lh_low: rdata=%h to=%0d, expected 00000000", rd, to);
    end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic err, to; int lat, nwe; logic [9:0] wa;
    logic        we_t   [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  size_t [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] addr_t [3] = '{32'h11, 32'h13, 32'h10};
    for (int i = 0; i < 3; i++) begin
      do_op(we_t[i], size_t[i], 1'b0, addr_t[i], 32'h5A5A_5A5A, rd, err, lat, nwe, wa, to);
      tests_run++;
      if (to || err !== 1'b1 || lat != 1 || nwe != 0 || rd !== 32'h0) begin
        tests_failed++;
        $display("FAIL err_case%0d: to=%0d err=%b lat=%0d we_cycles=%0d rdata=%h, expected err=1 lat=1 we_cycles=0 rdata=0",
                 i, to, err, lat, nwe, rd);
      end
    end
    tests_run++;
    if (mem[4] !== 32'h8001_0000) begin
      tests_failed++;
      $display("FAIL err_mem_unchanged: mem[4]=%h, expected 80010000", mem[4]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd; logic err, to; int lat, nwe; logic [9:0] wa;
    int c = 0;
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, rd, err, lat, nwe, wa, to);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b00; req_addr_i = 32'h10;
    req_wdata_i = 32'h55;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    while (!mem_we_o && c < 5) begin
      @(negedge clk_i);
      c++;
    end
    tests_run++;
    if (!mem_we_o) begin
      tests_failed++;
      $display("FAIL rst_mid_reach_wr: mem_we_o=%b, expected 1 within 5 cycles", mem_we_o);
    end
    #1 rst_ni = 1'b0;
    #1;
    tests_run++;
    if (mem_we_o !== 1'b0 || req_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_drop: mem_we_o=%b ready=%b, expected we=0 ready=1", mem_we_o, req_ready_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if (mem[4] !== 32'h1122_3344 || rsp_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_mem: mem[4]=%h rsp_valid=%b, expected 11223344 valid=0", mem[4], rsp_valid_o);
    end
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, lat, nwe, wa, to);
    tests_run++;
    if (to || rd !== 32'h1122_3344 || lat != 2) begin
      tests_failed++;
      $display("FAIL rst_mid_reload: rdata=%h lat=%0d to=%0d, expected 11223344 lat=2", rd, lat, to);
    end
  endtask

  // Random traffic over 16 words; upper address bits are randomised to exercise index wrap.
  task automatic test_random();
    logic [31:0] rd; logic err, to; int lat, nwe; logic [9:0] wa;
    logic [31:0] addr, wdata, exp_rd;
    logic [1:0]  size;
    logic        we, uns, exp_err;
    int          idx, lane, exp_lat, exp_nwe;
    for (int w = 0; w < 16; w++) begin
      wdata = $urandom;
      do_op(1'b1, 2'b10, 1'b0, 32'(w * 4), wdata, rd, err, lat, nwe, wa, to);
      ref_mem[w] = wdata;
    end
    for (int n = 0; n < 300; n++) begin
      idx = $urandom_range(0, 15);
      lane = $urandom_range(0, 3);
      addr = {$urandom_range(0, 1048575), 12'h0} | 32'(idx * 4 + lane);
      size = 2'($urandom_range(0, 3));
      we = 1'($urandom);
      uns = 1'($urandom);
      wdata = $urandom;
      exp_err = ref_bad(size, addr);
      exp_rd = '0;
      exp_nwe = 0;
      if (exp_err) exp_lat = 1;
      else if (!we) begin
        exp_lat = 2;
        exp_rd = ref_load(ref_mem[idx], lane, size, uns);
      end else begin
        exp_lat = (size == 2'b10) ? 2 : 3;
        exp_nwe = 1;
        ref_mem[idx] = ref_store(ref_mem[idx], lane, size, wdata);
      end
      do_op(we, size, uns, addr, wdata, rd, err, lat, nwe, wa, to);
      tests_run++;
      if (to || rd !== exp_rd || err !== exp_err || lat != exp_lat || nwe != exp_nwe ||
          (exp_nwe == 1 && wa !== 10'(idx))) begin
        tests_failed++;
        $display("FAIL rand_op%0d: we=%b size=%0d addr=%h to=%0d rdata=%h err=%b lat=%0d we_cycles=%0d waddr=%0d, expected rdata=%h err=%b lat=%0d we_cycles=%0d waddr=%0d",
                 n, we, size, addr, to, rd, err, lat, nwe, wa, exp_rd, exp_err, exp_lat, exp_nwe, idx);
      end
    end
    for (int w = 0; w < 16; w++) begin
      do_op(1'b0, 2'b10, 1'b0, 32'(w * 4), 32'h0, rd, err, lat, nwe, wa, to);
      tests_run++;
      if (to || rd !== ref_mem[w]) begin
        tests_failed++;
        $display("FAIL rand_final_word%0d: rdata=%h to=%0d, expected %h", w, rd, to, ref_mem[w]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_error();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
